// File: rtl/router_dst_port_n.sv
// N-channel destination-side output buffer: per-channel FIFO, registered read
// port and a read-timeout flush that raises a one-cycle soft_reset pulse.
module router_dst_port_n #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int NUM_CH  = 3,
    parameter int TIMEOUT = 30
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          data_in,
    input  logic [NUM_CH-1:0]         write_enb,
    input  logic [NUM_CH-1:0]         read_enb,
    output logic [NUM_CH*WIDTH-1:0]   data_out,
    output logic [NUM_CH-1:0]         valid_out,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH-1:0]         soft_reset
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CW-1:0]    tmo_cnt;
        logic [WIDTH-1:0] rd_data;
        logic             sr_pulse;
        logic [WIDTH-1:0] mem [DEPTH];

        logic ch_empty;
        logic ch_full;
        logic hold_clear;
        logic flush;
        logic do_write;
        logic do_read;

        // The extra pointer MSB tells a full FIFO apart from an empty one.
        assign ch_empty   = (wr_ptr == rd_ptr);
        assign ch_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        assign hold_clear = ch_empty | read_enb[ch];
        assign flush      = !hold_clear && (tmo_cnt == TMO_LAST);
        assign do_write   = write_enb[ch] & ~ch_full & ~flush;
        assign do_read    = read_enb[ch] & ~ch_empty;

        // NOTE: storage array has no reset; every read is gated by empty, so
        // unwritten words are never observed and the array stays plain RAM.
        always_ff @(posedge clock) begin
            if (do_write)
                mem[wr_ptr[AW-1:0]] <= data_in;
        end

        // NOTE: all state updates use non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write)
                    wr_ptr <= wr_ptr + PW'(1);
                if (flush)
                    rd_ptr <= wr_ptr;
                else if (do_read)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                tmo_cnt <= '0;
            else if (hold_clear || flush)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + CW'(1);
        end

        // Read data is held across empty reads and across a flush.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_data  <= '0;
                sr_pulse <= 1'b0;
            end else begin
                sr_pulse <= flush;
                if (do_read)
                    rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end

        assign data_out[ch*WIDTH +: WIDTH] = rd_data;
        assign empty[ch]      = ch_empty;
        assign full[ch]       = ch_full;
        assign valid_out[ch]  = ~ch_empty;
        assign soft_reset[ch] = sr_pulse;
    end

endmodule

// File: tb/tb_router_dst_port_n.sv
// Self-checking bench for router_dst_port_n: directed scenarios followed by
// randomized traffic, all compared against a circular-buffer reference model.
module tb_router_dst_port_n;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int NUM_CH  = 3;
    localparam int TIMEOUT = 30;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [WIDTH-1:0]        data_in;
    logic [NUM_CH-1:0]       write_enb;
    logic [NUM_CH-1:0]       read_enb;
    logic [NUM_CH*WIDTH-1:0] data_out;
    logic [NUM_CH-1:0]       valid_out;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       soft_reset;

    router_dst_port_n #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .write_enb(write_enb), .read_enb(read_enb), .data_out(data_out),
        .valid_out(valid_out), .full(full), .empty(empty), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    // Reference model: each channel is a circular buffer with an occupancy
    // count, plus the number of consecutive unserviced non-empty cycles.
    logic [WIDTH-1:0] m_mem  [NUM_CH][DEPTH];
    int               m_head [NUM_CH];
    int               m_cnt  [NUM_CH];
    int               m_idle [NUM_CH];
    logic [WIDTH-1:0] m_dout [NUM_CH];
    logic             m_sr   [NUM_CH];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_head[ch] = 0;
            m_cnt[ch]  = 0;
            m_idle[ch] = 0;
            m_dout[ch] = '0;
            m_sr[ch]   = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit was_empty = (m_cnt[ch] == 0);
            bit was_full  = (m_cnt[ch] == DEPTH);
            bit rd        = read_enb[ch];
            bit wr        = write_enb[ch];
            bit timed_out = !was_empty && !rd && (m_idle[ch] == TIMEOUT - 1);
            m_sr[ch] = timed_out;
            if (timed_out) begin
                m_cnt[ch]  = 0;
                m_idle[ch] = 0;
            end else begin
                if (rd && !was_empty) begin
                    m_dout[ch] = m_mem[ch][m_head[ch]];
                    m_head[ch] = (m_head[ch] + 1) % DEPTH;
                    m_cnt[ch]--;
                end
                if (wr && !was_full) begin
                    m_mem[ch][(m_head[ch] + m_cnt[ch]) % DEPTH] = data_in;
                    m_cnt[ch]++;
                end
                m_idle[ch] = (was_empty || rd) ? 0 : m_idle[ch] + 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("ch%0d empty", ch), 64'(empty[ch]), 64'(m_cnt[ch] == 0));
            check($sformatf("ch%0d full", ch), 64'(full[ch]), 64'(m_cnt[ch] == DEPTH));
            check($sformatf("ch%0d valid_out", ch), 64'(valid_out[ch]), 64'(m_cnt[ch] != 0));
            check($sformatf("ch%0d data_out", ch), 64'(data_out[ch*WIDTH +: WIDTH]), 64'(m_dout[ch]));
            check($sformatf("ch%0d soft_reset", ch), 64'(soft_reset[ch]), 64'(m_sr[ch]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [NUM_CH-1:0] we, input logic [NUM_CH-1:0] re,
                         input logic [WIDTH-1:0] d);
        write_enb = we;
        read_enb  = re;
        data_in   = d;
        step();
    endtask

    initial begin
        int sr_at;
        int rd_div;

        reset     = 1'b1;
        data_in   = '0;
        write_enb = '0;
        read_enb  = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset
        repeat (5) drive('0, '0, '0);
        check("idle empty", 64'(empty), 64'(3'b111));
        check("idle valid", 64'(valid_out), 64'(0));
        check("idle full", 64'(full), 64'(0));
        check("idle data", 64'(data_out), 64'(0));
        check("idle soft_reset", 64'(soft_reset), 64'(0));

        // Three words through channel 1
        drive(3'b010, '0, 8'h11);
        drive(3'b010, '0, 8'h22);
        drive(3'b010, '0, 8'h33);
        drive('0, 3'b010, '0);
        check("ch1 rd0", 64'(data_out[15:8]), 64'(8'h11));
        drive('0, 3'b010, '0);
        check("ch1 rd1", 64'(data_out[15:8]), 64'(8'h22));
        drive('0, 3'b010, '0);
        check("ch1 rd2", 64'(data_out[15:8]), 64'(8'h33));
        check("ch1 drained", 64'(empty[1]), 64'(1));
        check("ch0/ch2 untouched", 64'({data_out[23:16], data_out[7:0]}), 64'(0));

        // Fill channel 0, overflow attempt, drain, then pointer wrap
        for (int i = 0; i < DEPTH; i++) drive(3'b001, '0, WIDTH'(i));
        check("ch0 full", 64'(full[0]), 64'(1));
        drive(3'b001, '0, 8'hFF);
        for (int i = 0; i < DEPTH; i++) begin
            drive('0, 3'b001, '0);
            check("ch0 drain", 64'(data_out[7:0]), 64'(i));
        end
        check("ch0 empty after drain", 64'(empty[0]), 64'(1));
        drive(3'b001, '0, 8'h40);
        for (int i = 1; i <= 8; i++) drive(3'b001, 3'b001, WIDTH'(8'h40 + i));
        check("ch0 wrap data", 64'(data_out[7:0]), 64'(8'h47));
        drive('0, 3'b001, '0);
        check("ch0 wrap last", 64'(data_out[7:0]), 64'(8'h48));

        // Timeout flush on channel 2
        drive(3'b100, '0, 8'hA5);
        sr_at = -1;
        for (int k = 1; k <= 40; k++) begin
            drive('0, '0, '0);
            if (soft_reset[2] && sr_at < 0) sr_at = k;
        end
        check("ch2 timeout cycle", 64'(sr_at), 64'(TIMEOUT));
        check("ch2 empty after flush", 64'(empty[2]), 64'(1));

        // A read at cycle 20 restarts the timeout
        drive(3'b100, '0, 8'hB1);
        drive(3'b100, '0, 8'hB2);
        sr_at = -1;
        for (int k = 2; k <= 60; k++) begin
            drive('0, (k == 20) ? 3'b100 : 3'b000, '0);
            if (soft_reset[2] && sr_at < 0) sr_at = k;
        end
        check("ch2 restart timeout cycle", 64'(sr_at), 64'(20 + TIMEOUT));
        check("ch2 restart read data", 64'(data_out[23:16]), 64'(8'hB1));

        // Asynchronous reset with a read in flight
        for (int i = 0; i < 5; i++) drive(3'b001, '0, WIDTH'(8'hC0 + i));
        drive('0, 3'b001, '0);
        write_enb = '0;
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("async rst empty", 64'(empty), 64'(3'b111));
        check("async rst data", 64'(data_out), 64'(0));
        check("async rst valid", 64'(valid_out), 64'(0));
        read_enb = '0;
        @(negedge clock);
        reset = 1'b0;
        drive(3'b001, '0, 8'h5A);
        drive('0, 3'b001, '0);
        check("post rst data", 64'(data_out[7:0]), 64'(8'h5A));

        // Randomized traffic with phases of sparse and busy readers
        rd_div = 2;
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_CH-1:0] re;
            if (c % 250 == 0) rd_div = (rd_div == 2) ? 45 : 2;
            for (int ch = 0; ch < NUM_CH; ch++)
                re[ch] = ($urandom_range(rd_div - 1) == 0);
            drive(NUM_CH'($urandom), re, WIDTH'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_dst_port_n.md
Name: router_dst_port_n

Overview:
- Parametrised N-channel destination-side output buffer for the router. It generalises the single destination port (data_out / read_enb / valid_out) to N independent channels.
- Each channel owns a DEPTH-word FIFO, a registered read port and a programmable-length read-timeout soft reset.
- Sits between the router write-side FSM (drives per-channel write strobes) and N destination consumers (drive read_enb).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, words per channel FIFO; must be a power of 2, >= 2.
- NUM_CH, 3, number of destination channels.
- TIMEOUT, 30, consecutive cycles valid_out may be high without read_enb before that channel is flushed; >= 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  write data, shared by all channels.
- write_enb  in  NUM_CH  per-channel write strobe; more than one bit may be high.
- read_enb  in  NUM_CH  per-channel read request from the destination.
- data_out  out  NUM_CH*WIDTH  registered read data; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_out  out  NUM_CH  channel i FIFO non-empty.
- full  out  NUM_CH  channel i FIFO holds DEPTH words.
- empty  out  NUM_CH  channel i FIFO holds 0 words.
- soft_reset  out  NUM_CH  1-cycle pulse when channel i is flushed by timeout.

Behaviour:
- Reset (asynchronous, active-high), all channels:
  - read/write pointers = 0; timeout counters = 0.
  - data_out = 0, soft_reset = 0, valid_out = 0, full = 0, empty = all 1s.
  - FIFO memory contents are don't-care.
  - Assertion mid-operation discards all stored words immediately.
- Pointers are log2(DEPTH)+1 bits. The MSB disambiguates full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal AND MSBs differ.
  - Pointers wrap naturally at 2*DEPTH.
- full, empty and valid_out are combinational from the pointers; valid_out = ~empty.
- Write: on a clock edge with write_enb[i] = 1 and full[i] = 0:
  - mem_i[wr_ptr] <= data_in; wr_ptr increments.
  - Write with full[i] = 1 is dropped silently, even if a read occurs the same cycle.
- Read: on a clock edge with read_enb[i] = 1 and empty[i] = 0:
  - data_out slice i <= mem_i[rd_ptr]; rd_ptr increments.
  - Latency: data appears the cycle after the read edge.
  - Read when empty: no pointer change; data_out holds its previous value.
- Simultaneous read and write on a non-empty, non-full channel: both occur; occupancy is unchanged.
- Write to an empty channel with read_enb high the same cycle: the write occurs and the read is ignored. The word becomes readable the following cycle.
- Timeout counter (per channel, width clog2(TIMEOUT+1)):
  - Cleared when empty[i] = 1 or read_enb[i] = 1.
  - Otherwise increments each cycle while valid_out[i] = 1.
  - When the counter reaches TIMEOUT-1 and the clearing condition is false, on the next edge:
    - rd_ptr := wr_ptr (flush); counter := 0.
    - soft_reset[i] = 1 for exactly that following cycle; data_out slice i is held.
  - A write to channel i on the flush edge is dropped, so the FIFO is empty afterwards.
- Channels are fully independent: a flush, full or empty condition on one channel has no effect on the others.
- No X propagation: data_out never reads an unwritten location, because reads are gated by empty.

Test Plan:
- Reset then idle 5 cycles -> empty = 3'b111, valid_out = 0, full = 0, data_out = 0, soft_reset = 0.
- Write 0x11, 0x22, 0x33 to ch1, then hold read_enb[1] for 3 cycles -> data_out[15:8] = 0x11, 0x22, 0x33 on successive cycles, each one cycle after its read edge; empty[1] = 1 afterwards; ch0 and ch2 untouched.
- Write 16 words 0x00..0x0F to ch0 -> full[0] = 1 after the 16th edge. A 17th write of 0xFF is dropped; 16 reads return 0x00..0x0F. Then 8 more write/read pairs exercise pointer wrap.
- Write 1 word to ch2 and keep read_enb[2] = 0 for 30 cycles -> soft_reset[2] pulses high for 1 cycle in the 31st cycle after the write; empty[2] = 1 thereafter.
- Same as the timeout case, but pulse read_enb[2] at cycle 20 with a second word queued -> counter restarts and no soft_reset occurs before cycle 50.
- Assert reset while ch0 holds 5 words and a read is in flight -> empty[0] = 1 and data_out = 0 immediately (asynchronous); after release, a new write/read returns the new word.
